// File: rtl/spi_slave_rx_if.sv
// Bus bundle between an SPI master-side environment and the spi_slave_rx
// endpoint: serial pins plus the receive/transmit handshake and status flags.
interface spi_slave_rx_if #(
  parameter int unsigned frame_size = 8
);
  logic                  SCLK;
  logic                  SE;
  logic                  MOSI;
  logic                  MISO;
  logic [frame_size-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [frame_size-1:0] tx_data;
  logic                  tx_load;
  logic                  frame_error;
  logic                  overrun;
  logic                  clear_flags;

  modport slave (
    input  SCLK, SE, MOSI, rx_ready, tx_data, tx_load, clear_flags,
    output MISO, rx_data, rx_valid, frame_error, overrun
  );

  modport master (
    output SCLK, SE, MOSI, rx_ready, tx_data, tx_load, clear_flags,
    input  MISO, rx_data, rx_valid, frame_error, overrun
  );
endinterface

// File: rtl/spi_slave_rx.sv
// SPI slave receiver: oversamples SCLK/SE/MOSI on ckl, assembles LSB-first
// frames, hands them out on a valid/ready handshake, flags aborts and
// overruns, and shifts a preloaded reply word out on MISO.
module spi_slave_rx #(
  parameter int unsigned frame_size  = 8,
  parameter int unsigned sync_stages = 2
) (
  input logic           ckl,
  input logic           rst_n,
  spi_slave_rx_if.slave bus
);

  localparam int unsigned CW = $clog2(frame_size);

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  logic [sync_stages-1:0] sclk_sync_q, se_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, se_prev_q;
  logic                   sclk_s, se_s, mosi_s;
  logic                   sclk_rise, sclk_fall, se_fall;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [frame_size-1:0]  rx_sh_q, tx_sh_q, tx_hold_q, rx_data_q;
  logic                   rx_valid_q, frame_error_q, overrun_q;
  logic [frame_size-1:0]  tx_next;

  // Synchronize the serial pins; SE resets low so a reset taken mid-frame
  // (SE still low) is not mistaken for a fresh SE falling edge.
  always_ff @(posedge ckl or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      se_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      se_prev_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[sync_stages-2:0], bus.SCLK};
      se_sync_q   <= {se_sync_q[sync_stages-2:0], bus.SE};
      mosi_sync_q <= {mosi_sync_q[sync_stages-2:0], bus.MOSI};
      sclk_prev_q <= sclk_sync_q[sync_stages-1];
      se_prev_q   <= se_sync_q[sync_stages-1];
    end
  end

  // Edge detection and the reply word to use at the next frame start.
  always_comb begin
    sclk_s    = sclk_sync_q[sync_stages-1];
    se_s      = se_sync_q[sync_stages-1];
    mosi_s    = mosi_sync_q[sync_stages-1];
    sclk_rise = sclk_s & ~sclk_prev_q;
    sclk_fall = ~sclk_s & sclk_prev_q;
    se_fall   = ~se_s & se_prev_q;
    tx_next   = bus.tx_load ? bus.tx_data : tx_hold_q;
  end

  // Frame FSM with handshake, sticky flags and the MISO shifter; MISO is the
  // shifter's bit 0, so clearing the shifter drives MISO low in IDLE.
  always_ff @(posedge ckl or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rx_sh_q       <= '0;
      tx_sh_q       <= '0;
      tx_hold_q     <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      if (bus.tx_load) tx_hold_q <= bus.tx_data;
      if (bus.clear_flags) begin
        frame_error_q <= 1'b0;
        overrun_q     <= 1'b0;
      end
      if (rx_valid_q && bus.rx_ready) rx_valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          cnt_q   <= '0;
          tx_sh_q <= '0;
          if (se_fall) begin
            state_q <= ACTIVE;
            tx_sh_q <= tx_next;
          end
        end
        ACTIVE: begin
          if (se_s) begin
            if (cnt_q != '0) frame_error_q <= 1'b1;
            cnt_q   <= '0;
            rx_sh_q <= '0;
            tx_sh_q <= '0;
            state_q <= IDLE;
          end else if (sclk_fall) begin
            rx_sh_q[cnt_q] <= mosi_s;
            cnt_q          <= cnt_q + CW'(1);
            if (cnt_q == CW'(frame_size - 1)) state_q <= DONE;
          end else if (sclk_rise && cnt_q != '0) begin
            tx_sh_q <= {1'b0, tx_sh_q[frame_size-1:1]};
          end
        end
        DONE: begin
          // An accept on this same edge frees the slot, so no overrun then.
          if (!rx_valid_q || bus.rx_ready) begin
            rx_data_q  <= rx_sh_q;
            rx_valid_q <= 1'b1;
          end else begin
            overrun_q <= 1'b1;
          end
          cnt_q   <= '0;
          rx_sh_q <= '0;
          if (se_s) begin
            tx_sh_q <= '0;
            state_q <= IDLE;
          end else begin
            tx_sh_q <= tx_next;
            state_q <= ACTIVE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Registered outputs onto the bus.
  always_comb begin
    bus.MISO        = tx_sh_q[0];
    bus.rx_data     = rx_data_q;
    bus.rx_valid    = rx_valid_q;
    bus.frame_error = frame_error_q;
    bus.overrun     = overrun_q;
  end

endmodule
